onfi_init_seq: RTL and testbench
================================

ONFI_INIT_SEQ -- requirements
Module: onfi_init_seq

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 100, minimum clk cycles between start and the first R/B# ready check.
REQ-002 SHALL have parameter T_WB_CYC, default 10, clk cycles ignored after reset command completion before R/B# is sampled (tWB).
REQ-003 SHALL have parameter T_TIMEOUT_CYC, default 100000, per-state wait limit in clk cycles (1 ms at 100 MHz).
REQ-004 SHALL have parameter CNT_W, default 20, cycle counter width; must satisfy 2^CNT_W > max(POWERUP_CYC, T_WB_CYC, T_TIMEOUT_CYC).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 start  input  1  one-cycle request to run the device init sequence.
REQ-008 onfi_rbn  input  1  device R/B# pin, asynchronous; 1 = ready, 0 = busy.
REQ-009 rst_cmd_go  output  1  one-cycle pulse launching the downstream reset-command generator (FFh on onfi_cen/cle/ale/wen/dq).
REQ-010 rst_cmd_done  input  1  one-cycle pulse from the reset-command generator: command fully driven on the bus.
REQ-011 busy  output  1  sequence in progress.
REQ-012 init_done  output  1  level; device reset complete and ready.
REQ-013 init_err  output  1  level; a wait timed out.

Function
REQ-014 onfi_rbn SHALL pass through a 2-flop synchronizer (rbn_s) before use; both flops reset to 0; fixed 2-cycle sampling latency.
REQ-015 FSM states SHALL be IDLE, PWRUP, ISSUE, WAIT_CMD, WAIT_WB, WAIT_RDY, DONE, ERR.
REQ-016 A single cycle counter cnt SHALL clear to 0 on every state transition and otherwise increment by 1 per cycle, saturating at all-ones.
REQ-017 IDLE/DONE/ERR: start=1 -> PWRUP next cycle; start in any other state SHALL be ignored.
REQ-018 PWRUP: cnt >= POWERUP_CYC-1 and rbn_s=1 -> ISSUE.
REQ-019 ISSUE: unconditional -> WAIT_CMD after exactly one cycle; rst_cmd_go=1 exactly for the cycle the FSM is in ISSUE.
REQ-020 WAIT_CMD: rst_cmd_done=1 -> WAIT_WB; rst_cmd_done in any other state SHALL be ignored.
REQ-021 WAIT_WB: cnt = T_WB_CYC-1 -> WAIT_RDY; rbn_s ignored in this state.
REQ-022 WAIT_RDY: rbn_s=1 -> DONE.
REQ-023 Timeout: in PWRUP, WAIT_CMD, WAIT_RDY, cnt = T_TIMEOUT_CYC-1 with exit condition false -> ERR; if exit condition and timeout coincide, exit SHALL win.
REQ-024 Outputs SHALL be registered (state-decoded from registered state): busy=1 in PWRUP..WAIT_RDY; init_done=1 only in DONE; init_err=1 only in ERR.
REQ-025 Latency: start at cycle N -> busy=1 at N+1; with rbn_s already 1, rst_cmd_go pulses at cycle N+POWERUP_CYC+1.
REQ-026 Leaving DONE/ERR via start SHALL clear init_done/init_err on the same edge busy rises.

Reset
REQ-027 rst=1 SHALL force state IDLE, cnt=0, rbn_s flops=0, and rst_cmd_go=busy=init_done=init_err=0 on the next edge, from any state including mid-sequence.
REQ-028 start asserted together with rst SHALL be ignored; outputs return to 0 regardless of a pending rst_cmd_done.

Verification (bench params POWERUP_CYC=4, T_WB_CYC=3, T_TIMEOUT_CYC=50)
REQ-029 Nominal: rbn=1, start at cycle 10, rst_cmd_done 5 cycles after go, rbn low 2 cycles after done for 20 cycles -> one rst_cmd_go pulse at cycle 15, init_done=1, init_err=0, busy low thereafter.
REQ-030 Power-up busy: rbn=0 until cycle 30, start at 10 -> rst_cmd_go no earlier than cycle 33 (sync latency), then normal completion.
REQ-031 Stuck busy: rbn held 0 after rst_cmd_done -> init_err=1 exactly 50 cycles after WAIT_RDY entry, init_done=0, busy=0.
REQ-032 Missing done: rst_cmd_done never pulses -> init_err=1 50 cycles after WAIT_CMD entry; a stray rst_cmd_done in WAIT_RDY changes nothing.
REQ-033 Reset mid-op: rst at cycle 2 of WAIT_WB -> all outputs 0 next cycle, state IDLE; new start runs full sequence with exactly one rst_cmd_go.
REQ-034 Restart/ignore: start pulses during busy produce no extra rst_cmd_go; start in DONE clears init_done and reruns sequence.

Source files
------------

// File: rtl/onfi_init_seq.sv
// ONFI power-up/reset sequencer: waits for R/B# ready, issues the FFh reset
// command through a downstream generator, then waits for the device to come ready.
module onfi_init_seq #(
    parameter int unsigned POWERUP_CYC   = 100,
    parameter int unsigned T_WB_CYC      = 10,
    parameter int unsigned T_TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic onfi_rbn,
    output logic rst_cmd_go,
    input  logic rst_cmd_done,
    output logic busy,
    output logic init_done,
    output logic init_err
);

    typedef enum logic [2:0] {
        IDLE,
        PWRUP,
        ISSUE,
        WAIT_CMD,
        WAIT_WB,
        WAIT_RDY,
        DONE,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(T_WB_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(T_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               rbn_meta;
    logic               rbn_s;
    logic               go_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;

    // Two-flop synchronizer for the asynchronous R/B# pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbn_meta <= 1'b0;
            rbn_s    <= 1'b0;
        end else begin
            rbn_meta <= onfi_rbn;
            rbn_s    <= rbn_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Exit conditions are tested before the timeout so a coincident exit wins.
    always_comb begin
        state_d = state_q;
        go_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = PWRUP;
            end
            PWRUP: begin
                if (cnt_q >= PWR_LAST && rbn_s) state_d = ISSUE;
                else if (cnt_q == TO_LAST)      state_d = ERR;
            end
            ISSUE: begin
                state_d = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (rst_cmd_done)          state_d = WAIT_WB;
                else if (cnt_q == TO_LAST) state_d = ERR;
            end
            WAIT_WB: begin
                if (cnt_q == WB_LAST) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rbn_s)                 state_d = DONE;
                else if (cnt_q == TO_LAST) state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        go_d   = (state_d == ISSUE);
        busy_d = (state_d == PWRUP) || (state_d == ISSUE) || (state_d == WAIT_CMD) ||
                 (state_d == WAIT_WB) || (state_d == WAIT_RDY);
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
    end

    // Per-state cycle counter: restarts on every transition, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs are flops loaded with the decode of the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cmd_go <= 1'b0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
        end else begin
            rst_cmd_go <= go_d;
            busy       <= busy_d;
            init_done  <= done_d;
            init_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_onfi_init_seq.sv
// Bench for onfi_init_seq: directed and random R/B#/done scenarios checked
// against an event-time prediction derived from the sequencing rules.
module tb_onfi_init_seq;

    localparam int P_CYC  = 4;
    localparam int WB_CYC = 3;
    localparam int TO_CYC = 50;
    localparam int WLEN   = 512;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic onfi_rbn;
    logic rst_cmd_done;
    logic rst_cmd_go;
    logic busy;
    logic init_done;
    logic init_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic rbn_wave [0:WLEN-1];

    onfi_init_seq #(
        .POWERUP_CYC  (P_CYC),
        .T_WB_CYC     (WB_CYC),
        .T_TIMEOUT_CYC(TO_CYC),
        .CNT_W        (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .onfi_rbn    (onfi_rbn),
        .rst_cmd_go  (rst_cmd_go),
        .rst_cmd_done(rst_cmd_done),
        .busy        (busy),
        .init_done   (init_done),
        .init_err    (init_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_high();
        for (int i = 0; i < WLEN; i++) rbn_wave[i] = 1'b1;
    endtask

    task automatic add_low(input int a, input int len);
        for (int i = a; i < a + len && i < WLEN; i++) rbn_wave[i] = 1'b0;
    endtask

    // Event times (scenario-relative cycles): rbn seen by the FSM at cycle k is
    // the pin value driven at k-2; each wait gives up after TO_CYC cycles.
    function automatic void predict(input int ts, input int dd, output int go,
                                    output int w, output int fin, output bit err);
        go  = -1;
        w   = -1;
        fin = -1;
        err = 1'b1;
        for (int k = ts + P_CYC; k <= ts + TO_CYC; k++)
            if (rbn_wave[k-2] == 1'b1) begin go = k + 1; break; end
        if (go < 0) begin
            fin = ts + TO_CYC + 1;
        end else if (dd < 1 || dd > TO_CYC) begin
            fin = go + TO_CYC + 1;
        end else begin
            w   = go + dd + WB_CYC + 1;
            fin = w + TO_CYC;
            for (int k = w; k < w + TO_CYC; k++)
                if (rbn_wave[k-2] == 1'b1) begin fin = k + 1; err = 1'b0; break; end
        end
    endfunction

    task automatic run_scn(input string tag, input int ts, input int dd,
                           input bit stray_start, input bit stray_done);
        int   go_e, w_e, fin_e;
        bit   err_e;
        int   go_o, n_go, fin_o, done_at, s1;
        logic err_o, done_o, busy_ts1, clr_ts1, busy_pre, busy_fin;
        predict(ts, dd, go_e, w_e, fin_e, err_e);
        go_o = -1; n_go = 0; fin_o = -1; done_at = -1;
        err_o = 1'bx; done_o = 1'bx; busy_ts1 = 1'bx; clr_ts1 = 1'bx;
        busy_pre = 1'bx; busy_fin = 1'bx;
        s1 = ts + 2 + int'($urandom_range(0, fin_e - ts - 3));
        for (int r = 0; r <= fin_e + 3; r++) begin
            step();
            if (rst_cmd_go === 1'b1) begin
                n_go++;
                if (go_o < 0) begin
                    go_o = r;
                    if (dd >= 0) done_at = r + dd;
                end
            end
            if (r > ts && fin_o < 0 && (init_done === 1'b1 || init_err === 1'b1)) begin
                fin_o  = r;
                done_o = init_done;
                err_o  = init_err;
            end
            if (r == ts + 1) begin
                busy_ts1 = busy;
                clr_ts1  = init_done | init_err;
            end
            if (r == fin_e - 1) busy_pre = busy;
            if (r == fin_e)     busy_fin = busy;
            start        = (r == ts) || (stray_start && (r == s1 || r == fin_e - 1));
            rst_cmd_done = (r == done_at) ||
                           (stray_done && (r == ts + 1 || (w_e >= 0 && fin_e > w_e + 1 && r == w_e + 1)));
            onfi_rbn     = rbn_wave[r];
        end
        start        = 1'b0;
        rst_cmd_done = 1'b0;
        check_eq({tag, ".go_cyc"},   go_o, go_e);
        check_eq({tag, ".go_cnt"},   n_go, (go_e >= 0) ? 1 : 0);
        check_eq({tag, ".busy_up"},  {31'd0, busy_ts1}, 1);
        check_eq({tag, ".flag_clr"}, {31'd0, clr_ts1}, 0);
        check_eq({tag, ".end_cyc"},  fin_o, fin_e);
        check_eq({tag, ".err"},      {31'd0, err_o}, int'(err_e));
        check_eq({tag, ".done"},     {31'd0, done_o}, int'(!err_e));
        check_eq({tag, ".busy_pre"}, {31'd0, busy_pre}, 1);
        check_eq({tag, ".busy_end"}, {31'd0, busy_fin}, 0);
    endtask

    // Reset in the second WAIT_WB cycle, then reset held with start and done.
    task automatic reset_mid();
        int   go_e, w_e, fin_e, go_o, rst_at;
        bit   err_e;
        logic busy_at;
        set_high();
        predict(4, 2, go_e, w_e, fin_e, err_e);
        rst_at  = go_e + 4;
        go_o    = -1;
        busy_at = 1'bx;
        for (int r = 0; r <= rst_at; r++) begin
            step();
            if (rst_cmd_go === 1'b1 && go_o < 0) go_o = r;
            if (r == rst_at) busy_at = busy;
            start        = (r == 4);
            rst_cmd_done = (go_o >= 0 && r == go_o + 2);
            onfi_rbn     = rbn_wave[r];
            rst          = (r == rst_at);
        end
        check_eq("rstmid.go_cyc", go_o, go_e);
        check_eq("rstmid.busy_wb", {31'd0, busy_at}, 1);
        step();
        check_eq("rstmid.outs", {28'd0, rst_cmd_go, busy, init_done, init_err}, 0);
        start        = 1'b1;
        rst_cmd_done = 1'b1;
        step();
        check_eq("rst_start.outs", {28'd0, rst_cmd_go, busy, init_done, init_err}, 0);
        rst          = 1'b0;
        start        = 1'b0;
        rst_cmd_done = 1'b0;
        step();
        check_eq("rst_start.idle", {28'd0, rst_cmd_go, busy, init_done, init_err}, 0);
    endtask

    initial begin
        int ts, dd;
        bit ss, sd;
        rst          = 1'b1;
        start        = 1'b0;
        onfi_rbn     = 1'b1;
        rst_cmd_done = 1'b0;
        repeat (3) step();
        check_eq("reset.outs", {28'd0, rst_cmd_go, busy, init_done, init_err}, 0);
        rst = 1'b0;

        set_high(); add_low(22, 20);    run_scn("nominal",  10, 5, 1'b0, 1'b0);
        set_high(); add_low(0, 30);     run_scn("pwr_busy", 10, 5, 1'b0, 1'b0);
        set_high(); add_low(19, WLEN);  run_scn("stuck",    10, 3, 1'b0, 1'b0);
        set_high();                     run_scn("no_done",  10, -1, 1'b0, 1'b1);
        set_high(); add_low(16, 15);    run_scn("stray",    5, 4, 1'b1, 1'b1);
        set_high();                     run_scn("edge_to",  3, TO_CYC, 1'b0, 1'b0);
        reset_mid();
        set_high();                     run_scn("after_rst", 3, 2, 1'b0, 1'b0);

        repeat (24) begin
            set_high();
            repeat ($urandom_range(0, 3)) add_low(int'($urandom_range(0, 150)), int'($urandom_range(1, 60)));
            if ($urandom_range(0, 4) == 0) add_low(int'($urandom_range(20, 150)), WLEN);
            ts = int'($urandom_range(2, 8));
            case ($urandom_range(0, 9))
                0:       dd = -1;
                1:       dd = TO_CYC;
                2:       dd = TO_CYC + 1;
                default: dd = int'($urandom_range(1, 8));
            endcase
            ss = 1'($urandom_range(0, 1));
            sd = 1'($urandom_range(0, 1));
            run_scn("rand", ts, dd, ss, sd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
